// File: rtl/toast_pkg.sv
// Shared types and helpers for the toaster cycle controller.
package toast_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAT = 2'd1,
      DONE = 2'd2
   } toast_state_t;

   typedef logic [3:0] bcd_digit_t;

   // Heater on-time per PWM period: a quarter of the period per shade step.
   function automatic int unsigned duty_for(logic [1:0] shade, int unsigned period);
      return ((int'(shade) + 1) * period) / 4;
   endfunction

endpackage

// File: rtl/toast_ctrl_if.sv
// Button/shade inputs and display/heater outputs of the toast controller.
// Buttons are level signals sampled on every rising clk edge; there is no
// handshake, outputs are valid after each edge.
interface toast_ctrl_if;
   logic        start_btn;
   logic        stop_btn;
   logic [1:0]  shade;
   logic [11:0] time_left;
   logic        heat_pwm;
   logic        busy;
   logic        done;

   modport slave (
      input  start_btn, stop_btn, shade,
      output time_left, heat_pwm, busy, done
   );

   modport master (
      output start_btn, stop_btn, shade,
      input  time_left, heat_pwm, busy, done
   );
endinterface

// File: rtl/bcd_down3.sv
// Three-digit BCD decrement that saturates at 000 instead of wrapping to 999.
module bcd_down3
   import toast_pkg::*;
(
   input  logic [11:0] val_i,
   output logic [11:0] val_o
);

   bcd_digit_t d0, d1, d2;

   assign d0 = val_i[3:0];
   assign d1 = val_i[7:4];
   assign d2 = val_i[11:8];

   // Ripple the borrow from the units digit upward.
   always_comb begin
      val_o = val_i;
      if (val_i == 12'h000) begin
         val_o = 12'h000;
      end else if (d0 != 4'd0) begin
         val_o[3:0] = d0 - 4'd1;
      end else begin
         val_o[3:0] = 4'd9;
         if (d1 != 4'd0) begin
            val_o[7:4] = d1 - 4'd1;
         end else begin
            val_o[7:4]  = 4'd9;
            val_o[11:8] = d2 - 4'd1;
         end
      end
   end

endmodule

// File: rtl/toast_ctrl.sv
// Toast-cycle controller: start/stop sequencing, BCD countdown, heater PWM.
module toast_ctrl
   import toast_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 2000,
   parameter int unsigned PWM_PERIOD = 20,
   parameter int unsigned DONE_S     = 3,
   parameter logic [11:0] T0         = 12'h060,
   parameter logic [11:0] T1         = 12'h090,
   parameter logic [11:0] T2         = 12'h120,
   parameter logic [11:0] T3         = 12'h150
) (
   input  logic         clk,
   input  logic         reset_n,
   toast_ctrl_if.slave  bus_if,
   output toast_state_t state_o
);

   localparam int unsigned DONE_CYC = DONE_S * CLK_HZ;
   localparam int unsigned PRESC_W  = (CLK_HZ > 1)     ? $clog2(CLK_HZ)     : 1;
   localparam int unsigned PWM_W    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int unsigned DONE_W   = (DONE_CYC > 1)   ? $clog2(DONE_CYC)   : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
   localparam logic [PWM_W-1:0]   PWM_LAST   = PWM_W'(PWM_PERIOD - 1);
   localparam logic [DONE_W-1:0]  DONE_LAST  = DONE_W'(DONE_CYC - 1);

   toast_state_t        state_q;
   logic [1:0]          shade_q;
   logic [11:0]         time_left_q;
   logic [PRESC_W-1:0]  presc_q;
   logic [PWM_W-1:0]    pwm_q;
   logic [DONE_W-1:0]   done_cnt_q;
   logic                start_q;

   logic [11:0]         preset;
   logic [11:0]         time_dec;
   logic                start_edge;
   logic [31:0]         duty;

   // Preset seconds for the currently selected shade.
   always_comb begin
      preset = T0;
      case (bus_if.shade)
         2'd0:    preset = T0;
         2'd1:    preset = T1;
         2'd2:    preset = T2;
         default: preset = T3;
      endcase
   end

   bcd_down3 u_dec (
      .val_i (time_left_q),
      .val_o (time_dec)
   );

   assign start_edge = bus_if.start_btn && !start_q;
   assign duty       = duty_for(shade_q, PWM_PERIOD);

   // Main sequencer: stop wins over completion/tick, which wins over start.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shade_q     <= 2'd0;
         time_left_q <= 12'h000;
         presc_q     <= '0;
         pwm_q       <= '0;
         done_cnt_q  <= '0;
         start_q     <= 1'b0;
      end else begin
         // Edge register follows the button even when an edge is dropped,
         // so a held button cannot fire later.
         start_q <= bus_if.start_btn;
         case (state_q)
            IDLE: begin
               time_left_q <= preset;
               if (start_edge && !bus_if.stop_btn) begin
                  state_q <= HEAT;
                  shade_q <= bus_if.shade;
                  presc_q <= '0;
                  pwm_q   <= '0;
               end
            end
            HEAT: begin
               if (bus_if.stop_btn) begin
                  state_q <= IDLE;
                  presc_q <= '0;
                  pwm_q   <= '0;
               end else begin
                  pwm_q <= (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
                  if (presc_q == PRESC_LAST) begin
                     presc_q     <= '0;
                     time_left_q <= time_dec;
                     // A preset of 000 also completes on its first tick.
                     if (time_left_q <= 12'h001) begin
                        state_q    <= DONE;
                        done_cnt_q <= '0;
                     end
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus_if.stop_btn) begin
                  state_q    <= IDLE;
                  done_cnt_q <= '0;
               end else if (done_cnt_q == DONE_LAST) begin
                  state_q    <= IDLE;
                  done_cnt_q <= '0;
               end else if (start_edge) begin
                  state_q     <= HEAT;
                  shade_q     <= bus_if.shade;
                  time_left_q <= preset;
                  presc_q     <= '0;
                  pwm_q       <= '0;
                  done_cnt_q  <= '0;
               end else begin
                  done_cnt_q <= done_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      bus_if.time_left = time_left_q;
      bus_if.busy      = (state_q == HEAT);
      bus_if.done      = (state_q == DONE);
      bus_if.heat_pwm  = (state_q == HEAT) && (32'(pwm_q) < duty);
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_toast_ctrl.sv
// Directed bench for toast_ctrl with small timing parameters.
module tb_toast_ctrl;
  import toast_pkg::*;

  logic clk;
  logic reset_n;
  toast_state_t state;
  int tests = 0;
  int failed = 0;

  toast_ctrl_if bus ();

  toast_ctrl #(
    .CLK_HZ(8), .PWM_PERIOD(4), .DONE_S(2),
    .T0(12'h003), .T1(12'h010), .T2(12'h120), .T3(12'h100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_if  (bus.slave),
    .state_o (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle away from it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_out(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pwm"},  32'(bus.heat_pwm), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
  endtask

  logic [7:0] pat_s1;

  initial begin
    pat_s1 = 8'b0011_0011; // bit n = heat_pwm n cycles after entry (1100 1100)
    reset_n = 1'b0;
    bus.start_btn = 1'b0;
    bus.stop_btn  = 1'b0;
    bus.shade     = 2'd0;
    tick(2);
    check("rst_time", 32'(bus.time_left), 32'h000);
    check_idle_out("rst");

    reset_n = 1'b1;
    tick();
    check("preview_s0", 32'(bus.time_left), 32'h003);

    // shade 0 full run
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_time", 32'(bus.time_left), 32'h003);
    check("t1_pwm0", 32'(bus.heat_pwm), 32'd1);
    tick();
    check("t1_pwm1", 32'(bus.heat_pwm), 32'd0);
    tick(6);
    check("t1_hold7", 32'(bus.time_left), 32'h003);
    tick();
    check("t1_8", 32'(bus.time_left), 32'h002);
    tick(8);
    check("t1_16", 32'(bus.time_left), 32'h001);
    tick(8);
    check("t1_24", 32'(bus.time_left), 32'h000);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_busy24", 32'(bus.busy), 32'd0);
    check("t1_pwm24", 32'(bus.heat_pwm), 32'd0);
    tick(15);
    check("t1_done15", 32'(bus.done), 32'd1);
    tick();
    check_idle_out("t1_end");
    tick();
    check("t1_preview", 32'(bus.time_left), 32'h003);

    // shade 1: pwm 1100, borrow 010 -> 009
    bus.shade = 2'd1;
    tick();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    check("t2_time", 32'(bus.time_left), 32'h010);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t2_pwm%0d", n), 32'(bus.heat_pwm), 32'(pat_s1[n]));
      tick();
    end
    check("t2_borrow", 32'(bus.time_left), 32'h009);
    bus.stop_btn = 1'b1;
    bus.shade = 2'd3;
    tick();
    bus.stop_btn = 1'b0;
    check_idle_out("t2_stop");
    tick();
    check("t2_preview", 32'(bus.time_left), 32'h100);

    // shade 3: constant heat, borrow 100 -> 099
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check($sformatf("t3_pwm%0d", n), 32'(bus.heat_pwm), 32'd1);
      tick();
    end
    check("t3_borrow", 32'(bus.time_left), 32'h099);
    bus.stop_btn = 1'b1;
    tick();
    bus.stop_btn = 1'b0;
    check_idle_out("t3_stop");

    // stop 5 cycles into HEAT; shade change in HEAT ignored
    bus.shade = 2'd1;
    tick();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    bus.shade = 2'd3;
    tick(5);
    check("t4_busy", 32'(bus.busy), 32'd1);
    bus.stop_btn = 1'b1;
    tick();
    bus.stop_btn = 1'b0;
    check_idle_out("t4_stop");
    check("t4_held", 32'(bus.time_left), 32'h010);
    tick();
    check("t4_preview", 32'(bus.time_left), 32'h100);

    // start+stop together in IDLE: edge dropped, never re-fires
    bus.shade = 2'd0;
    bus.start_btn = 1'b1;
    bus.stop_btn  = 1'b1;
    tick();
    check_idle_out("t5_both");
    bus.stop_btn = 1'b0;
    tick();
    check_idle_out("t5_release");
    tick();
    check("t5_still", 32'(state), 32'(IDLE));
    bus.start_btn = 1'b0;
    tick();

    // run to DONE, then restart from DONE with shade 1
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    tick(24);
    check("t5_done", 32'(bus.done), 32'd1);
    tick(3);
    bus.shade = 2'd1;
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    check("t5_restart_busy", 32'(bus.busy), 32'd1);
    check("t5_restart_done", 32'(bus.done), 32'd0);
    check("t5_restart_time", 32'(bus.time_left), 32'h010);

    // reset mid-HEAT
    tick(3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_time", 32'(bus.time_left), 32'h000);
    check_idle_out("t6_rst");
    tick();
    check("t6_preview", 32'(bus.time_left), 32'h010);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
